// File: rtl/timer_sched_pkg.sv
// Shared types for the multi-channel timer scheduler: command opcodes and
// interrupt arbiter states.
package timer_sched_pkg;

  typedef enum logic [1:0] {
    OP_ONESHOT  = 2'd0,
    OP_PERIODIC = 2'd1,
    OP_STOP     = 2'd2,
    OP_RSVD     = 2'd3
  } cmd_op_t;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_IRQ  = 1'b1
  } arb_state_t;

endpackage

// File: rtl/tick_gen.sv
// Free-running prescaler: one-cycle tick every PERIOD clocks, never reset by
// commands.
module tick_gen #(
  parameter int PERIOD = 1000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int PW = $clog2(PERIOD);

  logic [PW-1:0] pcnt_q, pcnt_d;

  always_comb begin
    tick   = (pcnt_q == PW'(PERIOD - 1));
    pcnt_d = tick ? '0 : pcnt_q + PW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pcnt_q <= '0;
    else      pcnt_q <= pcnt_d;
  end

endmodule

// File: rtl/timer_sched.sv
// NCH countdown channels sharing one prescaler; expiries are presented to the
// CPU one at a time through a round-robin irq/irq_ack arbiter.
module timer_sched
  import timer_sched_pkg::*;
#(
  parameter int NCH    = 4,
  parameter int WIDTH  = 16,
  parameter int PERIOD = 1000,
  localparam int CW    = $clog2(NCH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CW-1:0]    cmd_ch,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [CW-1:0]    rd_ch,
  output logic [WIDTH-1:0] rd_counter,
  output logic [NCH-1:0]   active,
  output logic [NCH-1:0]   overrun,
  output logic             irq,
  output logic [CW-1:0]    irq_ch,
  input  logic             irq_ack
);

  logic                            tick;
  logic [NCH-1:0][WIDTH-1:0]       counter_q, counter_d, reload_q, reload_d;
  logic [NCH-1:0]                  periodic_q, periodic_d, active_q, active_d;
  logic [NCH-1:0]                  pending_q, pending_d, overrun_q, overrun_d;
  logic [NCH-1:0]                  cmd_sel;
  arb_state_t                      state_q, state_d;
  logic [CW-1:0]                   irq_ch_q, irq_ch_d, rr_ptr_q, rr_ptr_d;
  logic                            ack_fire;
  cmd_op_t                         op;

  tick_gen #(.PERIOD(PERIOD)) u_tick (.clk(clk), .rst(rst), .tick(tick));

  // First requester at or after ptr, wrapping; scanned backwards so the
  // nearest one wins.
  function automatic logic [CW-1:0] pick_rr(input logic [NCH-1:0] req,
                                            input logic [CW-1:0]  ptr);
    int idx;
    pick_rr = ptr;
    for (int k = NCH - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % NCH;
      if (req[idx]) pick_rr = CW'(idx);
    end
  endfunction

  assign op         = cmd_op_t'(cmd_op);
  assign cmd_ready  = 1'b1;
  assign rd_counter = counter_q[rd_ch];
  assign active     = active_q;
  assign overrun    = overrun_q;
  assign irq        = (state_q == ARB_IRQ);
  assign irq_ch     = irq_ch_q;

  always_comb begin
    for (int i = 0; i < NCH; i++) cmd_sel[i] = cmd_valid && (cmd_ch == CW'(i));
  end

  always_comb begin
    state_d  = state_q;
    irq_ch_d = irq_ch_q;
    rr_ptr_d = rr_ptr_q;
    ack_fire = 1'b0;
    case (state_q)
      ARB_IDLE: if (|pending_q) begin
        irq_ch_d = pick_rr(pending_q, rr_ptr_q);
        state_d  = ARB_IRQ;
      end
      ARB_IRQ: if (irq_ack) begin
        ack_fire = 1'b1;
        rr_ptr_d = (irq_ch_q == CW'(NCH - 1)) ? '0 : irq_ch_q + CW'(1);
        state_d  = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // A command to a channel overrides both the ack clear and a same-cycle expiry.
  always_comb begin
    counter_d  = counter_q;
    reload_d   = reload_q;
    periodic_d = periodic_q;
    active_d   = active_q;
    pending_d  = pending_q;
    overrun_d  = overrun_q;
    if (ack_fire) pending_d[irq_ch_q] = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (cmd_sel[i] && (op == OP_ONESHOT || op == OP_PERIODIC)) begin
        counter_d[i]  = cmd_data;
        reload_d[i]   = cmd_data;
        periodic_d[i] = (op == OP_PERIODIC);
        overrun_d[i]  = 1'b0;
        active_d[i]   = (cmd_data != '0);
        pending_d[i]  = (cmd_data == '0);
      end else if (cmd_sel[i] && op == OP_STOP) begin
        active_d[i]  = 1'b0;
        pending_d[i] = 1'b0;
      end else if (tick && active_q[i]) begin
        if (counter_q[i] == WIDTH'(1)) begin
          pending_d[i] = 1'b1;
          if (pending_q[i]) overrun_d[i] = 1'b1;
          if (periodic_q[i]) begin
            counter_d[i] = reload_q[i];
          end else begin
            counter_d[i] = '0;
            active_d[i]  = 1'b0;
          end
        end else begin
          counter_d[i] = counter_q[i] - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      counter_q  <= '0;
      reload_q   <= '0;
      periodic_q <= '0;
      active_q   <= '0;
      pending_q  <= '0;
      overrun_q  <= '0;
      state_q    <= ARB_IDLE;
      irq_ch_q   <= '0;
      rr_ptr_q   <= '0;
    end else begin
      counter_q  <= counter_d;
      reload_q   <= reload_d;
      periodic_q <= periodic_d;
      active_q   <= active_d;
      pending_q  <= pending_d;
      overrun_q  <= overrun_d;
      state_q    <= state_d;
      irq_ch_q   <= irq_ch_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

endmodule

// File: tb/tb_timer_sched.sv
// Bench for timer_sched: directed scenarios plus a random run against a
// per-cycle behavioural model of the channel/interrupt rules.
module tb_timer_sched;
  localparam int NCH = 4, WIDTH = 4, PERIOD = 3, CW = 2;

  logic clk = 1'b0, rst = 1'b0, cmd_valid = 1'b0, irq_ack = 1'b0;
  logic [1:0] cmd_op = '0;
  logic [CW-1:0] cmd_ch = '0, rd_ch = '0;
  logic [WIDTH-1:0] cmd_data = '0;
  logic cmd_ready, irq;
  logic [WIDTH-1:0] rd_counter;
  logic [NCH-1:0] active, overrun;
  logic [CW-1:0] irq_ch;

  int checks = 0, errors = 0;

  // model state
  int m_pc, m_irq, m_ch, m_rr;
  int m_cnt[NCH], m_rel[NCH], m_per[NCH], m_act[NCH], m_pend[NCH], m_ovr[NCH];

  timer_sched #(.NCH(NCH), .WIDTH(WIDTH), .PERIOD(PERIOD)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_ch(cmd_ch), .cmd_data(cmd_data), .rd_ch(rd_ch),
    .rd_counter(rd_counter), .active(active), .overrun(overrun),
    .irq(irq), .irq_ch(irq_ch), .irq_ack(irq_ack));

  always #5 clk = ~clk;

  task automatic model_reset();
    m_pc = 0; m_irq = 0; m_ch = 0; m_rr = 0;
    for (int i = 0; i < NCH; i++) begin
      m_cnt[i] = 0; m_rel[i] = 0; m_per[i] = 0; m_act[i] = 0; m_pend[i] = 0; m_ovr[i] = 0;
    end
  endtask

  // One clock of the specified behaviour, using the inputs present at the edge.
  task automatic model_update();
    int n_cnt[NCH], n_rel[NCH], n_per[NCH], n_act[NCH], n_pend[NCH], n_ovr[NCH];
    bit tk = (m_pc == PERIOD - 1);
    n_cnt = m_cnt; n_rel = m_rel; n_per = m_per; n_act = m_act; n_pend = m_pend; n_ovr = m_ovr;
    if (m_irq != 0) begin
      if (irq_ack) begin
        n_pend[m_ch] = 0; m_rr = (m_ch + 1) % NCH; m_irq = 0;
      end
    end else begin
      for (int k = 0; k < NCH; k++) begin
        int j = (m_rr + k) % NCH;
        if (m_pend[j] != 0) begin m_ch = j; m_irq = 1; break; end
      end
    end
    for (int i = 0; i < NCH; i++) begin
      bit hit = cmd_valid && (int'(cmd_ch) == i);
      if (hit && cmd_op <= 2'd1) begin
        n_cnt[i] = int'(cmd_data); n_rel[i] = int'(cmd_data); n_per[i] = int'(cmd_op);
        n_ovr[i] = 0; n_act[i] = (cmd_data != 0); n_pend[i] = (cmd_data == 0);
      end else if (hit && cmd_op == 2'd2) begin
        n_act[i] = 0; n_pend[i] = 0;
      end else if (tk && m_act[i] != 0) begin
        if (m_cnt[i] == 1) begin
          n_pend[i] = 1;
          if (m_pend[i] != 0) n_ovr[i] = 1;
          if (m_per[i] != 0) n_cnt[i] = m_rel[i];
          else begin n_cnt[i] = 0; n_act[i] = 0; end
        end else n_cnt[i] = m_cnt[i] - 1;
      end
    end
    m_cnt = n_cnt; m_rel = n_rel; m_per = n_per; m_act = n_act; m_pend = n_pend; m_ovr = n_ovr;
    m_pc = tk ? 0 : m_pc + 1;
  endtask

  task automatic step();
    @(posedge clk);
    if (!rst) model_reset(); else model_update();
    #1;
  endtask

  task automatic cmd(input int op, input int ch, input int data);
    cmd_valid = 1'b1; cmd_op = 2'(op); cmd_ch = CW'(ch); cmd_data = WIDTH'(data);
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic ack();
    irq_ack = 1'b1; step(); irq_ack = 1'b0;
  endtask

  task automatic align(input int pc);
    for (int n = 0; n < 2 * PERIOD && m_pc != pc; n++) step();
  endtask

  task automatic wait_irq(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 12; n++) begin
      if (irq === 1'b1) begin ok = 1'b1; return; end
      step();
    end
  endtask

  task automatic do_reset();
    rst = 1'b0; cmd_valid = 1'b0; irq_ack = 1'b0;
    model_reset();
    step(); step();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rst_irq got %0d want 0", irq); end
    checks++; if (active !== 4'h0) begin errors++; $display("FAIL rst_active got %h want 0", active); end
    checks++; if (overrun !== 4'h0) begin errors++; $display("FAIL rst_overrun got %h want 0", overrun); end
    cmd(1, 0, 5); cmd(0, 3, 0); step();
    checks++; if (irq !== 1'b1 || irq_ch !== 2'd3) begin errors++; $display("FAIL rst_pre_irq got %0d/%0d want 1/3", irq, irq_ch); end
    rd_ch = 2'd0;
    #2 rst = 1'b0; #1;
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rst_async_irq got %0d want 0", irq); end
    checks++; if (irq_ch !== 2'd0) begin errors++; $display("FAIL rst_async_irq_ch got %0d want 0", irq_ch); end
    checks++; if (active !== 4'h0 || rd_counter !== 4'd0) begin errors++; $display("FAIL rst_async_state got %h/%0d want 0/0", active, rd_counter); end
    step(); rst = 1'b1;
    cmd(0, 0, 2);
    checks++; if (rd_counter !== 4'd2) begin errors++; $display("FAIL rst_clk1 got %0d want 2", rd_counter); end
    step();
    checks++; if (rd_counter !== 4'd2) begin errors++; $display("FAIL rst_clk2 got %0d want 2", rd_counter); end
    step();
    checks++; if (rd_counter !== 4'd1) begin errors++; $display("FAIL rst_clk3_tick got %0d want 1", rd_counter); end
  endtask

  task automatic test_oneshot();
    do_reset(); rd_ch = 2'd1; align(1);
    cmd(0, 1, 2);
    checks++; if (rd_counter !== 4'd2 || active[1] !== 1'b1) begin errors++; $display("FAIL os_load got %0d/%0d want 2/1", rd_counter, active[1]); end
    step();
    checks++; if (rd_counter !== 4'd1) begin errors++; $display("FAIL os_first_tick got %0d want 1", rd_counter); end
    step(); step(); step();
    checks++; if (rd_counter !== 4'd0 || active[1] !== 1'b0 || irq !== 1'b0) begin
      errors++; $display("FAIL os_expire got cnt %0d act %0d irq %0d want 0/0/0", rd_counter, active[1], irq); end
    step();
    checks++; if (irq !== 1'b1 || irq_ch !== 2'd1) begin errors++; $display("FAIL os_irq got %0d/%0d want 1/1", irq, irq_ch); end
    ack();
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL os_ack got %0d want 0", irq); end
  endtask

  task automatic test_periodic();
    int exp_seq[6] = '{2, 1, 3, 2, 1, 3};
    do_reset(); rd_ch = 2'd0; align(1);
    cmd(1, 0, 3);
    checks++; if (rd_counter !== 4'd3) begin errors++; $display("FAIL per_load got %0d want 3", rd_counter); end
    for (int t = 0; t < 6; t++) begin
      step(); step(); step();
      checks++; if (rd_counter !== WIDTH'(exp_seq[t])) begin errors++; $display("FAIL per_seq%0d got %0d want %0d", t, rd_counter, exp_seq[t]); end
      if (t == 2) begin
        checks++; if (overrun[0] !== 1'b0) begin errors++; $display("FAIL per_no_ovr got %0d want 0", overrun[0]); end
      end
    end
    checks++; if (overrun[0] !== 1'b1) begin errors++; $display("FAIL per_ovr got %0d want 1", overrun[0]); end
    checks++; if (irq !== 1'b1 || irq_ch !== 2'd0) begin errors++; $display("FAIL per_irq got %0d/%0d want 1/0", irq, irq_ch); end
    cmd(0, 0, 7);
    checks++; if (overrun[0] !== 1'b0 || irq !== 1'b1) begin errors++; $display("FAIL per_reload got ovr %0d irq %0d want 0/1", overrun[0], irq); end
    ack(); step(); step();
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL per_cleared got %0d want 0", irq); end
  endtask

  task automatic test_round_robin();
    int seq[3] = '{0, 2, 3};
    bit ok;
    do_reset(); align(2);
    cmd(0, 0, 2); cmd(0, 2, 2); cmd(0, 3, 2);
    wait_irq(ok);
    checks++; if (!ok) begin errors++; $display("FAIL rr_wait got irq %0d want 1", irq); end
    for (int s = 0; s < 3; s++) begin
      checks++; if (irq_ch !== CW'(seq[s])) begin errors++; $display("FAIL rr_ch%0d got %0d want %0d", s, irq_ch, seq[s]); end
      ack();
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rr_gap%0d got %0d want 0", s, irq); end
      if (s < 2) begin
        step();
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL rr_rise%0d got %0d want 1", s, irq); end
      end
    end
    cmd(0, 0, 0);
    wait_irq(ok);
    checks++; if (!ok || irq_ch !== 2'd0) begin errors++; $display("FAIL rr_r2_pre got %0d/%0d want 1/0", irq, irq_ch); end
    ack();
    align(0); cmd(0, 0, 1); cmd(0, 2, 1);
    wait_irq(ok);
    checks++; if (!ok || irq_ch !== 2'd2) begin errors++; $display("FAIL rr_r2_first got %0d/%0d want 1/2", irq, irq_ch); end
    ack(); step();
    checks++; if (irq !== 1'b1 || irq_ch !== 2'd0) begin errors++; $display("FAIL rr_r2_second got %0d/%0d want 1/0", irq, irq_ch); end
    ack();
  endtask

  task automatic test_zero_stop();
    do_reset(); rd_ch = 2'd3;
    cmd(0, 3, 0);
    checks++; if (active[3] !== 1'b0 || rd_counter !== 4'd0 || irq !== 1'b0) begin
      errors++; $display("FAIL zero_load got act %0d cnt %0d irq %0d want 0/0/0", active[3], rd_counter, irq); end
    step();
    checks++; if (irq !== 1'b1 || irq_ch !== 2'd3) begin errors++; $display("FAIL zero_irq got %0d/%0d want 1/3", irq, irq_ch); end
    ack();
    rd_ch = 2'd1; align(1);
    cmd(0, 1, 2); step();
    checks++; if (rd_counter !== 4'd1) begin errors++; $display("FAIL stop_pre got %0d want 1", rd_counter); end
    cmd(2, 1, 0);
    checks++; if (active[1] !== 1'b0 || rd_counter !== 4'd1) begin errors++; $display("FAIL stop got act %0d cnt %0d want 0/1", active[1], rd_counter); end
    for (int n = 0; n < 6; n++) step();
    checks++; if (rd_counter !== 4'd1 || irq !== 1'b0 || active !== 4'h0) begin
      errors++; $display("FAIL stop_hold got cnt %0d irq %0d act %h want 1/0/0", rd_counter, irq, active); end
  endtask

  task automatic test_collision();
    do_reset(); rd_ch = 2'd2; align(0);
    cmd(0, 2, 1); step();
    cmd(0, 2, 5);
    checks++; if (rd_counter !== 4'd5 || active[2] !== 1'b1) begin errors++; $display("FAIL coll_load got %0d/%0d want 5/1", rd_counter, active[2]); end
    step(); step();
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL coll_irq got %0d want 0", irq); end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      logic [NCH-1:0] e_act, e_ovr;
      cmd_valid = ($urandom_range(0, 3) == 0);
      cmd_op    = 2'($urandom_range(0, 3));
      cmd_ch    = CW'($urandom_range(0, NCH - 1));
      cmd_data  = ($urandom_range(0, 4) == 0) ? '0 : WIDTH'($urandom_range(1, 6));
      irq_ack   = ($urandom_range(0, 2) == 0);
      rd_ch     = CW'($urandom_range(0, NCH - 1));
      step();
      for (int i = 0; i < NCH; i++) begin e_act[i] = (m_act[i] != 0); e_ovr[i] = (m_ovr[i] != 0); end
      checks++; if (irq !== (m_irq != 0)) begin errors++; $display("FAIL rnd_irq cyc %0d got %0d want %0d", n, irq, m_irq); end
      checks++; if (irq_ch !== CW'(m_ch)) begin errors++; $display("FAIL rnd_irq_ch cyc %0d got %0d want %0d", n, irq_ch, m_ch); end
      checks++; if (active !== e_act) begin errors++; $display("FAIL rnd_active cyc %0d got %h want %h", n, active, e_act); end
      checks++; if (overrun !== e_ovr) begin errors++; $display("FAIL rnd_overrun cyc %0d got %h want %h", n, overrun, e_ovr); end
      checks++; if (rd_counter !== WIDTH'(m_cnt[rd_ch])) begin errors++; $display("FAIL rnd_counter cyc %0d ch %0d got %0d want %0d", n, rd_ch, rd_counter, m_cnt[rd_ch]); end
      checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rnd_ready cyc %0d got %0d want 1", n, cmd_ready); end
    end
    cmd_valid = 1'b0; irq_ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_oneshot();
    test_periodic();
    test_round_robin();
    test_zero_stop();
    test_collision();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
